// File: rtl/arbitro_rr_4x4_pkg.sv
// rtl/arbitro_rr_4x4_pkg.sv - shared constants and grant helper for the 4x4 round-robin arbiter/router
package arbitro_rr_4x4_pkg;

   localparam int DATA_W   = 10;
   localparam int N_PORTS  = 4;
   localparam int DEST_MSB = DATA_W - 1;
   localparam int DEST_LSB = DATA_W - 2;

   // Rotating priority scan: the first requester at or after ptr (wrapping 3->0) wins.
   // Result is {valid, idx[1:0]}; valid=0 means no requester at all.
   function automatic logic [2:0] next_grant(input logic [N_PORTS-1:0] req,
                                             input logic [1:0]         ptr);
      logic [1:0] cand;
      logic [2:0] res;
      res  = 3'b000;
      cand = 2'd0;
      // Walk from the farthest candidate back to ptr so the nearest one is written last.
      for (int k = N_PORTS - 1; k >= 0; k--) begin
         cand = ptr + k[1:0];
         if (req[cand]) begin
            res = {1'b1, cand};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/arbitro_rr_4x4_if.sv
// rtl/arbitro_rr_4x4_if.sv - FIFO-side bundle between the arbiter and the input/output FIFOs
interface arbitro_rr_4x4_if;
   import arbitro_rr_4x4_pkg::*;

   logic [N_PORTS-1:0] fifo_empty;
   logic [DATA_W-1:0]  fifo_data_in0;
   logic [DATA_W-1:0]  fifo_data_in1;
   logic [DATA_W-1:0]  fifo_data_in2;
   logic [DATA_W-1:0]  fifo_data_in3;
   logic [N_PORTS-1:0] out_almost_full;
   logic [N_PORTS-1:0] pop;
   logic [N_PORTS-1:0] push;
   logic [DATA_W-1:0]  data_out;

   // Arbiter side: consumes FIFO status/data, drives strobes and the routed word.
   modport master (
      input  fifo_empty,
      input  fifo_data_in0,
      input  fifo_data_in1,
      input  fifo_data_in2,
      input  fifo_data_in3,
      input  out_almost_full,
      output pop,
      output push,
      output data_out
   );

   // FIFO side: supplies status/data, receives strobes and the routed word.
   modport slave (
      output fifo_empty,
      output fifo_data_in0,
      output fifo_data_in1,
      output fifo_data_in2,
      output fifo_data_in3,
      output out_almost_full,
      input  pop,
      input  push,
      input  data_out
   );

endinterface

// File: rtl/arbitro_rr_4x4_rr_grant4.sv
// rtl/arbitro_rr_4x4_rr_grant4.sv - combinational rotate-priority encoder (req, ptr -> one-hot grant, idx, valid)
module rr_grant4
   import arbitro_rr_4x4_pkg::*;
(
   input  logic [N_PORTS-1:0] req,
   input  logic [1:0]         ptr,
   output logic [N_PORTS-1:0] grant,
   output logic [1:0]         idx,
   output logic               valid
);

   logic [2:0] sel;

   // Pick the first requester starting from ptr and expand it to one-hot.
   always_comb begin
      sel   = next_grant(req, ptr);
      valid = sel[2];
      idx   = sel[1:0];
      grant = '0;
      if (sel[2]) begin
         grant = 4'b0001 << sel[1:0];
      end
   end

endmodule

// File: rtl/arbitro_rr_4x4.sv
// rtl/arbitro_rr_4x4.sv - 4-in/4-out round-robin pop/route/push arbiter; ARB_STRICT_PRIO_EN selects fixed priority 0>1>2>3
module arbitro_rr_4x4
   import arbitro_rr_4x4_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   output logic              idle,
   arbitro_rr_4x4_if.master  bus
);

   logic               stall;
   logic               issue;
   logic [N_PORTS-1:0] req;
   logic [N_PORTS-1:0] gnt_oh;
   logic [1:0]         gnt_idx;
   logic               gnt_valid;
   logic [1:0]         scan_ptr;
   logic [1:0]         gnt_q;
   logic               inflight;
   logic [DATA_W-1:0]  data_sel;
   logic [DATA_W-1:0]  data_q;
   logic [1:0]         dest;

   assign req   = ~bus.fifo_empty;
   assign stall = (|bus.out_almost_full) | ~enable;
   assign issue = gnt_valid & ~stall;

`ifdef ARB_STRICT_PRIO_EN
   // Fixed priority: the scan always starts at port 0.
   assign scan_ptr = 2'd0;
`else
   logic [1:0] rr_ptr;

   // Round-robin pointer: the port just served drops to lowest priority.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr <= 2'd0;
      end else if (issue) begin
         rr_ptr <= gnt_idx + 2'd1;
      end
   end

   assign scan_ptr = rr_ptr;
`endif

   rr_grant4 u_grant (
      .req   (req),
      .ptr   (scan_ptr),
      .grant (gnt_oh),
      .idx   (gnt_idx),
      .valid (gnt_valid)
   );

   // Pop strobe is combinational so an emptying FIFO or a new almost-full blocks it this cycle.
   always_comb begin
      bus.pop = '0;
      if (issue && reset) begin
         bus.pop = gnt_oh;
      end
   end

   // Issue stage: remember which port was popped; completion always follows one cycle later.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inflight <= 1'b0;
         gnt_q    <= 2'd0;
      end else begin
         inflight <= issue;
         if (issue) begin
            gnt_q <= gnt_idx;
         end
      end
   end

   // Read-data mux: the popped FIFO presents its word the cycle after the pop.
   always_comb begin
      data_sel = bus.fifo_data_in0;
      case (gnt_q)
         2'd0:    data_sel = bus.fifo_data_in0;
         2'd1:    data_sel = bus.fifo_data_in1;
         2'd2:    data_sel = bus.fifo_data_in2;
         default: data_sel = bus.fifo_data_in3;
      endcase
   end

   // Holding register so data_out keeps the last routed word between completions.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q <= '0;
      end else if (inflight) begin
         data_q <= data_sel;
      end
   end

   assign dest = data_sel[DEST_MSB:DEST_LSB];

   // Complete stage: route the in-flight word to the output FIFO named by its destination field.
   always_comb begin
      bus.push     = '0;
      bus.data_out = data_q;
      if (inflight) begin
         bus.data_out = data_sel;
         bus.push     = 4'b0001 << dest;
      end
   end

   assign idle = ~inflight & (&bus.fifo_empty);

endmodule
